// File: rtl/branch_resolve_unit_pkg.sv
// rtl/branch_resolve_unit_pkg.sv - shared pipeline types for branch resolution
package branch_resolve_unit_pkg;

  localparam int PC_W = 32;

  typedef logic [PC_W-1:0] pc_t;

  typedef struct packed {
    pc_t  pc;
    logic pred_taken;
    pc_t  pred_target;
  } entry_t;

  // Fall-through address of a branch; wraps modulo 2^PC_W.
  function automatic pc_t seq_pc(input pc_t pc);
    return pc + PC_W'(4);
  endfunction

endpackage

// File: rtl/branch_queue_fifo.sv
// rtl/branch_queue_fifo.sv - in-order storage of predicted branches with flush
module branch_queue_fifo
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  entry_t        wdata_i,
  output entry_t        rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);

  entry_t         mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Flush overrides any push or pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - resolves queued branch predictions, redirect/update pulses
// Optional statistics counters enabled by BRANCH_RESOLVE_STATS_EN.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PC_WIDTH  = PC_W,
  parameter int CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pushValid,
  output logic                       pushReady,
  input  logic [PC_WIDTH-1:0]        pushPc,
  input  logic                       pushPredTaken,
  input  logic [PC_WIDTH-1:0]        pushPredTarget,
  input  logic                       resolveValid,
  input  logic                       resolveTaken,
  input  logic [PC_WIDTH-1:0]        resolveTarget,
  output logic                       redirectValid,
  output logic [PC_WIDTH-1:0]        redirectPc,
  output logic                       updValid,
  output logic [PC_WIDTH-1:0]        updPc,
  output logic                       updTaken,
  output logic                       resolveErr,
`ifdef BRANCH_RESOLVE_STATS_EN
  output logic [CNT_WIDTH-1:0]       statResolved,
  output logic [CNT_WIDTH-1:0]       statMispredict,
`endif
  output logic [$clog2(DEPTH):0]     count
);

  localparam int CW = $clog2(DEPTH) + 1;

  entry_t                push_entry, head;
  logic                  fifo_full, fifo_empty, push_accept;
  logic                  resolve_fire, mispredict;
  logic [PC_WIDTH-1:0]   head_pc, head_target, correct_pc;

  logic                  redirect_valid_q, redirect_valid_d;
  logic [PC_WIDTH-1:0]   redirect_pc_q, redirect_pc_d;
  logic                  upd_valid_q, upd_valid_d;
  logic [PC_WIDTH-1:0]   upd_pc_q, upd_pc_d;
  logic                  upd_taken_q, upd_taken_d;
  logic                  resolve_err_q, resolve_err_d;

  always_comb begin
    push_entry.pc          = pc_t'(pushPc);
    push_entry.pred_taken  = pushPredTaken;
    push_entry.pred_target = pc_t'(pushPredTarget);
  end

  assign head_pc      = PC_WIDTH'(head.pc);
  assign head_target  = PC_WIDTH'(head.pred_target);
  assign resolve_fire = resolveValid && !fifo_empty;
  assign mispredict   = resolve_fire &&
                        ((resolveTaken != head.pred_taken) ||
                         (resolveTaken && (resolveTarget != head_target)));
  assign correct_pc   = resolveTaken ? resolveTarget : PC_WIDTH'(seq_pc(head.pc));

  // A full queue still accepts a push when the head retires cleanly this cycle.
  assign pushReady   = !fifo_full;
  assign push_accept = pushValid && !mispredict && (!fifo_full || resolve_fire);

  branch_queue_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_accept),
    .pop_i   (resolve_fire),
    .flush_i (mispredict),
    .wdata_i (push_entry),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  always_comb begin
    redirect_valid_d = mispredict;
    redirect_pc_d    = mispredict ? correct_pc : redirect_pc_q;
    upd_valid_d      = resolve_fire;
    upd_pc_d         = resolve_fire ? head_pc : upd_pc_q;
    upd_taken_d      = resolve_fire ? resolveTaken : upd_taken_q;
    resolve_err_d    = resolveValid && fifo_empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      upd_valid_q      <= 1'b0;
      upd_pc_q         <= '0;
      upd_taken_q      <= 1'b0;
      resolve_err_q    <= 1'b0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      upd_valid_q      <= upd_valid_d;
      upd_pc_q         <= upd_pc_d;
      upd_taken_q      <= upd_taken_d;
      resolve_err_q    <= resolve_err_d;
    end
  end

  assign redirectValid = redirect_valid_q;
  assign redirectPc    = redirect_pc_q;
  assign updValid      = upd_valid_q;
  assign updPc         = upd_pc_q;
  assign updTaken      = upd_taken_q;
  assign resolveErr    = resolve_err_q;

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [CNT_WIDTH-1:0] stat_res_q, stat_res_d;
  logic [CNT_WIDTH-1:0] stat_mis_q, stat_mis_d;

  always_comb begin
    stat_res_d = stat_res_q;
    stat_mis_d = stat_mis_q;
    if (resolve_fire && (stat_res_q != '1)) stat_res_d = stat_res_q + CNT_WIDTH'(1);
    if (mispredict && (stat_mis_q != '1))   stat_mis_d = stat_mis_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_res_q <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_res_q <= stat_res_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign statResolved   = stat_res_q;
  assign statMispredict = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - randomized self-checking bench with queue reference model
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;
  localparam int PCW   = 32;
`ifdef BRANCH_RESOLVE_STATS_EN
  localparam int CNTW  = 2;
`else
  localparam int CNTW  = 16;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             pushValid, pushReady, pushPredTaken;
  logic [PCW-1:0]   pushPc, pushPredTarget;
  logic             resolveValid, resolveTaken;
  logic [PCW-1:0]   resolveTarget;
  logic             redirectValid, updValid, updTaken, resolveErr;
  logic [PCW-1:0]   redirectPc, updPc;
  logic [2:0]       count;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [CNTW-1:0]  statResolved, statMispredict;
`endif

  always #5 clk = ~clk;

  branch_resolve_unit #(.DEPTH(DEPTH), .PC_WIDTH(PCW), .CNT_WIDTH(CNTW)) dut (
    .clk            (clk),
    .rst            (rst),
    .pushValid      (pushValid),
    .pushReady      (pushReady),
    .pushPc         (pushPc),
    .pushPredTaken  (pushPredTaken),
    .pushPredTarget (pushPredTarget),
    .resolveValid   (resolveValid),
    .resolveTaken   (resolveTaken),
    .resolveTarget  (resolveTarget),
    .redirectValid  (redirectValid),
    .redirectPc     (redirectPc),
    .updValid       (updValid),
    .updPc          (updPc),
    .updTaken       (updTaken),
    .resolveErr     (resolveErr),
`ifdef BRANCH_RESOLVE_STATS_EN
    .statResolved   (statResolved),
    .statMispredict (statMispredict),
`endif
    .count          (count)
  );

  typedef struct {
    logic [PCW-1:0] pc;
    logic           pt;
    logic [PCW-1:0] tgt;
  } ment_t;

  ment_t          mq[$];
  logic           exp_redir, exp_upd, exp_ut, exp_err;
  logic [PCW-1:0] exp_rpc, exp_upc;
  int             stat_res, stat_mis;
  int             n_checks = 0;
  int             n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    exp_redir = 0; exp_upd = 0; exp_err = 0; exp_ut = 0;
    exp_rpc = '0; exp_upc = '0;
    stat_res = 0; stat_mis = 0;
  endtask

  // One cycle: apply inputs after a falling edge, predict, then check at the next falling edge.
  task automatic step(input logic pv, input logic [PCW-1:0] ppc, input logic ppt,
                      input logic [PCW-1:0] ptgt, input logic rv, input logic rt,
                      input logic [PCW-1:0] rtgt);
    bit full, mis, fired;
    ment_t h;
    pushValid = pv; pushPc = ppc; pushPredTaken = ppt; pushPredTarget = ptgt;
    resolveValid = rv; resolveTaken = rt; resolveTarget = rtgt;
    #1;
    check("pushReady", 64'(pushReady), 64'(mq.size() < DEPTH));
    check("count", 64'(count), 64'(mq.size()));
    full = (mq.size() == DEPTH);
    mis = 0; fired = 0;
    exp_redir = 0; exp_upd = 0; exp_err = 0;
    if (rv) begin
      if (mq.size() == 0) exp_err = 1;
      else begin
        h = mq[0];
        fired = 1;
        exp_upd = 1; exp_upc = h.pc; exp_ut = rt;
        mis = (rt != h.pt) || (rt && (rtgt != h.tgt));
        if (stat_res < (1 << CNTW) - 1) stat_res++;
        if (mis) begin
          exp_redir = 1;
          exp_rpc = rt ? rtgt : h.pc + 32'd4;
          mq.delete();
          if (stat_mis < (1 << CNTW) - 1) stat_mis++;
        end else begin
          void'(mq.pop_front());
        end
      end
    end
    if (pv && !mis && (!full || fired)) mq.push_back('{ppc, ppt, ptgt});
    @(negedge clk);
    check("redirectValid", 64'(redirectValid), 64'(exp_redir));
    if (exp_redir) check("redirectPc", 64'(redirectPc), 64'(exp_rpc));
    check("updValid", 64'(updValid), 64'(exp_upd));
    if (exp_upd) begin
      check("updPc", 64'(updPc), 64'(exp_upc));
      check("updTaken", 64'(updTaken), 64'(exp_ut));
    end
    check("resolveErr", 64'(resolveErr), 64'(exp_err));
    check("count_after", 64'(count), 64'(mq.size()));
`ifdef BRANCH_RESOLVE_STATS_EN
    check("statResolved", 64'(statResolved), 64'(stat_res));
    check("statMispredict", 64'(statMispredict), 64'(stat_mis));
`endif
  endtask

  task automatic idle();
    step(0, '0, 0, '0, 0, 0, '0);
  endtask

  task automatic push(input logic [PCW-1:0] pc, input logic pt, input logic [PCW-1:0] tgt);
    step(1, pc, pt, tgt, 0, 0, '0);
  endtask

  task automatic resolve_ok();
    step(0, '0, 0, '0, 1, mq[0].pt, mq[0].tgt);
  endtask

  task automatic do_reset();
    rst = 1;
    pushValid = 0; pushPc = '0; pushPredTaken = 0; pushPredTarget = '0;
    resolveValid = 0; resolveTaken = 0; resolveTarget = '0;
    #1;
    check("rst_redirectValid", 64'(redirectValid), 64'd0);
    check("rst_redirectPc", 64'(redirectPc), 64'd0);
    check("rst_updValid", 64'(updValid), 64'd0);
    check("rst_updPc", 64'(updPc), 64'd0);
    check("rst_resolveErr", 64'(resolveErr), 64'd0);
    check("rst_count", 64'(count), 64'd0);
`ifdef BRANCH_RESOLVE_STATS_EN
    check("rst_statResolved", 64'(statResolved), 64'd0);
    check("rst_statMispredict", 64'(statMispredict), 64'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    model_clear();
  endtask

  initial begin
    logic [PCW-1:0] pc, tgt, rtgt;
    logic pt, rt;
    model_clear();
    rst = 1;
    @(negedge clk);
    do_reset();

    // Mispredicted not-taken vs taken: redirect to actual target.
    push(32'h100, 0, 32'h0);
    step(0, '0, 0, '0, 1, 1, 32'h200);
    check("d_redirect_pc", 64'(redirectPc), 64'h200);
    check("d_redirect_cnt", 64'(count), 64'd0);

    // Correct prediction: update pulse only.
    push(32'h100, 1, 32'h180);
    step(0, '0, 0, '0, 1, 1, 32'h180);
    check("d_upd_pc", 64'(updPc), 64'h100);
    check("d_no_redirect", 64'(redirectValid), 64'd0);

    // Full queue, then simultaneous push and correct resolve, then drain in order.
    for (int i = 0; i < DEPTH; i++) push(32'h400 + 32'(i * 8), 1, 32'h800 + 32'(i * 4));
    check("d_full_ready", 64'(pushReady), 64'd0);
    step(1, 32'h500, 0, 32'h0, 1, mq[0].pt, mq[0].tgt);
    check("d_full_cnt", 64'(count), 64'd4);
    check("d_full_upd", 64'(updPc), 64'h400);
    for (int i = 0; i < DEPTH; i++) resolve_ok();
    check("d_drained_last", 64'(updPc), 64'h500);

    // Wrap of fall-through PC and same-cycle push dropped by flush.
    push(32'hFFFF_FFFC, 1, 32'h40);
    push(32'h10, 0, 32'h0);
    push(32'h20, 0, 32'h0);
    step(1, 32'h30, 0, 32'h0, 1, 0, 32'h0);
    check("d_wrap_pc", 64'(redirectPc), 64'h0);
    check("d_wrap_cnt", 64'(count), 64'd0);

    // Resolve on empty queue.
    step(0, '0, 0, '0, 1, 1, 32'h44);
    check("d_err", 64'(resolveErr), 64'd1);
    check("d_err_noupd", 64'(updValid), 64'd0);
    idle();

`ifdef BRANCH_RESOLVE_STATS_EN
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push(32'h100, 0, 32'h0);
      step(0, '0, 0, '0, 1, 1, 32'h300);
    end
    check("d_stat_sat", 64'(statMispredict), 64'd3);
`endif

    // Randomized traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      pc  = (($urandom % 8) == 0) ? 32'hFFFF_FFFC : (32'h1000 + 32'(($urandom % 64) * 4));
      pt  = 1'($urandom);
      tgt = 32'h2000 + 32'(($urandom % 4) * 4);
      if (mq.size() > 0 && ($urandom % 3) != 0) begin
        rt = mq[0].pt; rtgt = mq[0].tgt;
      end else begin
        rt = 1'($urandom); rtgt = 32'h2000 + 32'(($urandom % 4) * 4);
      end
      step(1'(($urandom % 4) != 0), pc, pt, tgt, 1'(($urandom % 3) == 0), rt, rtgt);
    end
    idle();

    // Reset in mid-cycle right after a mispredict pulse has been launched.
    push(32'h700, 0, 32'h0);
    push(32'h704, 0, 32'h0);
    pushValid = 1; pushPc = 32'h708;
    resolveValid = 1; resolveTaken = 1; resolveTarget = 32'h900;
    @(posedge clk);
    #2 rst = 1;
    #1;
    check("mid_rst_redirect", 64'(redirectValid), 64'd0);
    check("mid_rst_upd", 64'(updValid), 64'd0);
    check("mid_rst_count", 64'(count), 64'd0);
`ifdef BRANCH_RESOLVE_STATS_EN
    check("mid_rst_stat", 64'(statResolved), 64'd0);
`endif
    @(negedge clk);
    do_reset();
    idle();
    step(0, '0, 0, '0, 1, 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
